ysyx_22040125_wb_arb: RTL and testbench

YSYX_22040125_WB_ARB -- requirements
Module: ysyx_22040125_wb_arb

---
 rtl/ysyx_22040125_pkg.sv | 15 +
 rtl/ysyx_22040125_rr_arb.sv | 28 ++
 rtl/ysyx_22040125_wb_arb.sv | 126 ++++++++++++
 tb/tb_ysyx_22040125_wb_arb.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040125_pkg.sv
// Shared write-back definitions: requester ids and default widths.
// Imported by the arbiter, its grant logic and the bench.
package ysyx_22040125_pkg;

  localparam int NREQ_DEF = 3;
  localparam int XLEN_DEF = 64;
  localparam int NREG     = 32;

  typedef enum logic [1:0] {
    REQ_ALU = 2'd0,
    REQ_LSU = 2'd1,
    REQ_MDU = 2'd2
  } req_id_e;

endpackage

// File: rtl/ysyx_22040125_rr_arb.sv
// Round-robin grant: search starts at ptr, first valid requester wins.
// Purely combinational, one-hot (or zero) grant.
module ysyx_22040125_rr_arb #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  int   w_pos;
  logic w_found;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < N; k++) begin
      w_pos = (int'(ptr) + k) % N;
      if (!w_found && req[w_pos]) begin
        grant[w_pos] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_22040125_wb_arb.sv
// Write-back arbiter: round-robin requester select, registered
// register-file write port and a busy scoreboard for issue.
module ysyx_22040125_wb_arb
  import ysyx_22040125_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int XLEN = XLEN_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [5*NREQ-1:0]    req_addr,
  input  logic [XLEN*NREQ-1:0] req_data,
  output logic                 wr_en,
  output logic [4:0]           wr_addr,
  output logic [XLEN-1:0]      wr_data,
  input  logic                 sb_set,
  input  logic [4:0]           sb_set_addr,
  input  logic [4:0]           qry_rs1,
  input  logic [4:0]           qry_rs2,
  output logic                 busy_rs1,
  output logic                 busy_rs2,
  input  logic                 flush,
  output logic                 sb_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   w_ptr_nxt;
  logic [NREQ-1:0] w_grant;
  logic            w_hs;
  logic [PW-1:0]   w_idx;
  logic [4:0]      w_addr;
  logic [XLEN-1:0] w_data;

  logic            r_wr_en;
  logic [4:0]      r_wr_addr;
  logic [XLEN-1:0] r_wr_data;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic [NREG-1:0] w_set_vec;
  logic [NREG-1:0] w_clr_vec;
  logic            w_sb_dup;
  logic            r_sb_err;

  ysyx_22040125_rr_arb #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (r_ptr),
    .grant (w_grant)
  );

  assign req_ready = w_grant & {NREQ{~flush & rst_n}};
  assign w_hs      = |(req_valid & req_ready);

  always_comb begin
    w_idx  = '0;
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        w_idx  = PW'(i);
        w_addr = req_addr[5*i +: 5];
        w_data = req_data[XLEN*i +: XLEN];
      end
    end
  end

  assign w_ptr_nxt = (int'(w_idx) == NREQ - 1) ? '0 : w_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_hs && (w_addr != 5'd0);
      if (w_hs) begin
        r_ptr     <= w_ptr_nxt;
        r_wr_addr <= w_addr;
        r_wr_data <= w_data;
      end
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

  // Set wins over the commit clear; flush beats both.
  assign w_set_vec = (sb_set && sb_set_addr != 5'd0)
                   ? (NREG'(1) << sb_set_addr) : '0;
  assign w_clr_vec = r_wr_en ? (NREG'(1) << r_wr_addr) : '0;
  assign w_sb_dup  = ~flush & (|(w_set_vec & r_busy & ~w_clr_vec));

  always_comb begin
    w_busy_nxt = (r_busy & ~w_clr_vec) | w_set_vec;
    if (flush) begin
      w_busy_nxt = '0;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= '0;
      r_sb_err <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_sb_dup) begin
        r_sb_err <= 1'b1;
      end
    end
  end

  assign busy_rs1 = r_busy[qry_rs1];
  assign busy_rs2 = r_busy[qry_rs2];
  assign sb_err   = r_sb_err;

endmodule

// File: tb/tb_ysyx_22040125_wb_arb.sv
// Directed vector bench for the write-back arbiter and scoreboard.
module tb_ysyx_22040125_wb_arb;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [191:0] req_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic        sb_set;
  logic [4:0]  sb_set_addr;
  logic [4:0]  qry_rs1;
  logic [4:0]  qry_rs2;
  logic        busy_rs1;
  logic        busy_rs2;
  logic        flush;
  logic        sb_err;

  int errors = 0;
  int checks = 0;

  ysyx_22040125_wb_arb #(.NREQ(3), .XLEN(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .sb_set      (sb_set),
    .sb_set_addr (sb_set_addr),
    .qry_rs1     (qry_rs1),
    .qry_rs2     (qry_rs2),
    .busy_rs1    (busy_rs1),
    .busy_rs2    (busy_rs2),
    .flush       (flush),
    .sb_err      (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  v;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [63:0] base;
    logic        st;
    logic [4:0]  sa;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        fl;
    logic [2:0]  rdy;
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        b1;
    logic        b2;
    logic        err;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    req_valid   = t.v;
    req_addr    = {t.a2, t.a1, t.a0};
    req_data    = {t.base + 64'd2, t.base + 64'd1, t.base};
    sb_set      = t.st;
    sb_set_addr = t.sa;
    qry_rs1     = t.q1;
    qry_rs2     = t.q2;
    flush       = t.fl;
  endtask

  initial begin
    // v a0 a1 a2 base st sa q1 q2 fl | rdy we wa wd b1 b2 err
    vq.push_back('{3'b111,5'd1,5'd2,5'd3,64'h100,1'b0,5'd0,5'd1,5'd2,1'b0,
                   3'b001,1'b0,5'd0,64'h0,1'b0,1'b0,1'b0});
    vq.push_back('{3'b111,5'd1,5'd2,5'd3,64'h200,1'b0,5'd0,5'd1,5'd2,1'b0,
                   3'b010,1'b1,5'd1,64'h100,1'b0,1'b0,1'b0});
    vq.push_back('{3'b111,5'd1,5'd2,5'd3,64'h300,1'b0,5'd0,5'd1,5'd2,1'b0,
                   3'b100,1'b1,5'd2,64'h201,1'b0,1'b0,1'b0});
    vq.push_back('{3'b111,5'd1,5'd2,5'd3,64'h400,1'b0,5'd0,5'd1,5'd2,1'b0,
                   3'b001,1'b1,5'd3,64'h302,1'b0,1'b0,1'b0});
    vq.push_back('{3'b000,5'd1,5'd2,5'd3,64'h0,1'b1,5'd5,5'd5,5'd1,1'b0,
                   3'b000,1'b1,5'd1,64'h400,1'b0,1'b0,1'b0});
    vq.push_back('{3'b010,5'd1,5'd5,5'd3,64'hDEADBEEE,1'b0,5'd0,5'd5,5'd0,1'b0,
                   3'b010,1'b0,5'd1,64'h400,1'b1,1'b0,1'b0});
    vq.push_back('{3'b000,5'd1,5'd2,5'd3,64'h0,1'b0,5'd0,5'd5,5'd0,1'b0,
                   3'b000,1'b1,5'd5,64'hDEADBEEF,1'b1,1'b0,1'b0});
    vq.push_back('{3'b000,5'd1,5'd2,5'd3,64'h0,1'b0,5'd0,5'd5,5'd0,1'b0,
                   3'b000,1'b0,5'd5,64'hDEADBEEF,1'b0,1'b0,1'b0});
    vq.push_back('{3'b000,5'd1,5'd2,5'd3,64'h0,1'b1,5'd4,5'd4,5'd0,1'b0,
                   3'b000,1'b0,5'd5,64'hDEADBEEF,1'b0,1'b0,1'b0});
    vq.push_back('{3'b100,5'd1,5'd2,5'd0,64'h900,1'b0,5'd0,5'd4,5'd0,1'b0,
                   3'b100,1'b0,5'd5,64'hDEADBEEF,1'b1,1'b0,1'b0});
    vq.push_back('{3'b000,5'd1,5'd2,5'd3,64'h0,1'b0,5'd0,5'd4,5'd0,1'b0,
                   3'b000,1'b0,5'd0,64'h902,1'b1,1'b0,1'b0});
    vq.push_back('{3'b000,5'd1,5'd2,5'd3,64'h0,1'b1,5'd7,5'd7,5'd0,1'b0,
                   3'b000,1'b0,5'd0,64'h902,1'b0,1'b0,1'b0});
    vq.push_back('{3'b001,5'd7,5'd2,5'd3,64'hA00,1'b0,5'd0,5'd7,5'd0,1'b0,
                   3'b001,1'b0,5'd0,64'h902,1'b1,1'b0,1'b0});
    vq.push_back('{3'b000,5'd1,5'd2,5'd3,64'h0,1'b1,5'd7,5'd7,5'd0,1'b0,
                   3'b000,1'b1,5'd7,64'hA00,1'b1,1'b0,1'b0});
    vq.push_back('{3'b000,5'd1,5'd2,5'd3,64'h0,1'b1,5'd7,5'd7,5'd0,1'b0,
                   3'b000,1'b0,5'd7,64'hA00,1'b1,1'b0,1'b0});
    vq.push_back('{3'b000,5'd1,5'd2,5'd3,64'h0,1'b0,5'd0,5'd7,5'd0,1'b0,
                   3'b000,1'b0,5'd7,64'hA00,1'b1,1'b0,1'b1});
    vq.push_back('{3'b000,5'd1,5'd2,5'd3,64'h0,1'b1,5'd3,5'd3,5'd0,1'b0,
                   3'b000,1'b0,5'd7,64'hA00,1'b0,1'b0,1'b1});
    vq.push_back('{3'b000,5'd1,5'd2,5'd3,64'h0,1'b1,5'd9,5'd3,5'd0,1'b0,
                   3'b000,1'b0,5'd7,64'hA00,1'b1,1'b0,1'b1});
    vq.push_back('{3'b001,5'd1,5'd2,5'd3,64'h0,1'b0,5'd0,5'd3,5'd9,1'b1,
                   3'b000,1'b0,5'd7,64'hA00,1'b1,1'b1,1'b1});
    vq.push_back('{3'b000,5'd1,5'd2,5'd3,64'h0,1'b0,5'd0,5'd3,5'd9,1'b0,
                   3'b000,1'b0,5'd7,64'hA00,1'b0,1'b0,1'b1});
    vq.push_back('{3'b010,5'd1,5'd9,5'd3,64'hB00,1'b0,5'd0,5'd9,5'd0,1'b0,
                   3'b010,1'b0,5'd7,64'hA00,1'b0,1'b0,1'b1});
    vq.push_back('{3'b001,5'd1,5'd2,5'd3,64'h0,1'b1,5'd6,5'd9,5'd0,1'b1,
                   3'b000,1'b1,5'd9,64'hB01,1'b0,1'b0,1'b1});
    vq.push_back('{3'b000,5'd1,5'd2,5'd3,64'h0,1'b0,5'd0,5'd6,5'd0,1'b0,
                   3'b000,1'b0,5'd9,64'hB01,1'b0,1'b0,1'b1});

    rst_n       = 1'b0;
    req_valid   = 3'b111;
    req_addr    = {5'd3, 5'd2, 5'd1};
    req_data    = '0;
    sb_set      = 1'b0;
    sb_set_addr = '0;
    qry_rs1     = 5'd1;
    qry_rs2     = 5'd2;
    flush       = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst wr_en", 64'(wr_en), 64'd0);
    chk("rst ready", 64'(req_ready), 64'd0);
    chk("rst busy1", 64'(busy_rs1), 64'd0);
    chk("rst busy2", 64'(busy_rs2), 64'd0);
    chk("rst sb_err", 64'(sb_err), 64'd0);
    chk("rst wr_addr", 64'(wr_addr), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 3'b000;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      chk($sformatf("v%0d ready", i), 64'(req_ready), 64'(vq[i].rdy));
      chk($sformatf("v%0d wr_en", i), 64'(wr_en), 64'(vq[i].we));
      chk($sformatf("v%0d wr_addr", i), 64'(wr_addr), 64'(vq[i].wa));
      chk($sformatf("v%0d wr_data", i), wr_data, vq[i].wd);
      chk($sformatf("v%0d busy1", i), 64'(busy_rs1), 64'(vq[i].b1));
      chk($sformatf("v%0d busy2", i), 64'(busy_rs2), 64'(vq[i].b2));
      chk($sformatf("v%0d sb_err", i), 64'(sb_err), 64'(vq[i].err));
    end

    // Reset lands while a write is pending on the port.
    @(negedge clk);
    req_valid = 3'b001;
    req_addr  = {5'd3, 5'd2, 5'd8};
    req_data  = {64'h0, 64'h0, 64'hC0DE};
    sb_set    = 1'b0;
    flush     = 1'b0;
    qry_rs1   = 5'd8;
    #1;
    chk("mid ready", 64'(req_ready), 64'b001);
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    chk("mid wr_en", 64'(wr_en), 64'd1);
    chk("mid wr_data", wr_data, 64'hC0DE);
    rst_n = 1'b0;
    #1;
    chk("mid rst wr_en", 64'(wr_en), 64'd0);
    chk("mid rst wr_addr", 64'(wr_addr), 64'd0);
    chk("mid rst wr_data", wr_data, 64'd0);
    chk("mid rst sb_err", 64'(sb_err), 64'd0);
    req_valid = 3'b111;
    #1;
    chk("mid rst ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 3'b000;
    @(posedge clk);
    #1;
    chk("post rst wr_en", 64'(wr_en), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
